// File: rtl/banked_reg_array.sv
// rtl/banked_reg_array.sv - banked register array with registered read port and bank-clear sequencer
// Optional feature macro: BANKED_REG_ARRAY_BYPASS_EN (same-cycle write-to-read forwarding)
module banked_reg_array #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int BANKS = 2,
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1,
    localparam int BW = (BANKS > 2) ? $clog2(BANKS) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [BW-1:0]    wr_bank,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [BW-1:0]    rd_bank,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             clr_req,
    input  logic [BW-1:0]    clr_bank,
    output logic             clr_busy,
    output logic             clr_done
);

    localparam int unsigned NB = BANKS;
    localparam int unsigned ND = DEPTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DONE
    } clr_state_t;

    clr_state_t       state_q;
    clr_state_t       state_d;
    logic [BW-1:0]    clr_bank_q;
    logic [AW-1:0]    clr_idx_q;
    logic             clr_start;
    logic             clr_last;
    logic             clr_req_ok;
    logic             wr_ok;
    logic             rd_in_range;
    logic [WIDTH-1:0] mem [BANKS][DEPTH];

    // Index and bank widths may cover more values than exist, so range checks are explicit
    assign clr_req_ok  = clr_req && (32'(clr_bank) < NB);
    assign clr_last    = (32'(clr_idx_q) == ND - 1);
    assign rd_in_range = (32'(rd_bank) < NB) && (32'(rd_addr) < ND);
    // Host writes into the bank being cleared are discarded so the clear result is all zeros
    assign wr_ok       = wr_en && (32'(wr_bank) < NB) && (32'(wr_addr) < ND)
                         && !(clr_busy && (wr_bank == clr_bank_q));

    // Clear sequencer state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear sequencer next state and status outputs; requests outside IDLE are dropped
    always_comb begin
        state_d   = state_q;
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        clr_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_req_ok) begin
                    clr_start = 1'b1;
                    state_d   = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clr_busy = 1'b1;
                if (clr_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                clr_done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latched target bank and walking clear index
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clr_bank_q <= '0;
            clr_idx_q  <= '0;
        end else if (clr_start) begin
            clr_bank_q <= clr_bank;
            clr_idx_q  <= '0;
        end else if (clr_busy) begin
            clr_idx_q  <= clr_last ? '0 : clr_idx_q + AW'(1);
        end
    end

    // Storage: clear sequencer zeroes one entry per cycle, host writes fill the rest
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < BANKS; b++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    mem[b][d] <= '0;
                end
            end
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    if (clr_busy && (clr_bank_q == BW'(b)) && (clr_idx_q == AW'(d))) begin
                        mem[b][d] <= '0;
                    end else if (wr_ok && (wr_bank == BW'(b)) && (wr_addr == AW'(d))) begin
                        mem[b][d] <= wr_data;
                    end
                end
            end
        end
    end

    // Registered read port; out-of-range reads still complete, returning zero
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                if (!rd_in_range) begin
                    rd_data <= '0;
`ifdef BANKED_REG_ARRAY_BYPASS_EN
                end else if (wr_ok && (wr_bank == rd_bank) && (wr_addr == rd_addr)) begin
                    rd_data <= wr_data;
`endif
                end else begin
                    rd_data <= mem[rd_bank][rd_addr];
                end
            end
        end
    end

endmodule

// File: doc/banked_reg_array.md
Name: banked_reg_array

Overview:
- Parametrised 2-D register array: BANKS banks × DEPTH entries × WIDTH bits.
- Provides one synchronous write port and one registered read port.
- Includes a hardware bank-clear sequencer (FSM) that zeroes one whole bank, one entry per cycle.
- Serves as the general storage primitive for per-channel state tables and small lookup memories.

Parameters:
- WIDTH, 8: bits per entry (≥1).
- DEPTH, 8: entries per bank (≥2; need not be a power of two).
- BANKS, 2: number of banks (≥1).
- Derived localparams, not overridable: AW = max(1, $clog2(DEPTH)); BW = max(1, $clog2(BANKS)).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rstn  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe.
- wr_bank  input  BW  write bank index.
- wr_addr  input  AW  write entry index.
- wr_data  input  WIDTH  write data.
- rd_en  input  1  read strobe.
- rd_bank  input  BW  read bank index.
- rd_addr  input  AW  read entry index.
- rd_data  output  WIDTH  registered read data.
- rd_valid  output  1  high one cycle after an accepted rd_en.
- clr_req  input  1  request to clear bank clr_bank.
- clr_bank  input  BW  bank to clear.
- clr_busy  output  1  clear in progress.
- clr_done  output  1  one-cycle pulse when a clear completes.

Behaviour:
- Reset (rstn low, asynchronous):
  - every entry of every bank = 0;
  - rd_data = 0, rd_valid = 0, clr_busy = 0, clr_done = 0;
  - FSM = IDLE, clear index = 0.
- Write:
  - wr_en=1 at a clock edge → entry[wr_bank][wr_addr] ← wr_data.
  - Dropped silently if wr_addr ≥ DEPTH or wr_bank ≥ BANKS.
- Read, latency 1:
  - rd_en=1 at edge N → rd_data = entry[rd_bank][rd_addr] sampled before edge-N writes; rd_valid=1 after edge N.
  - rd_en=0 → rd_valid=0 and rd_data holds its last value.
  - Out-of-range rd_addr or rd_bank → rd_data=0, rd_valid=1.
- Same entry written and read in the same cycle → read returns the OLD value (unless the optional feature is enabled).
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 with clr_bank < BANKS → latch the bank, index=0, go to CLEAR. clr_req with an out-of-range bank is ignored (no busy, no done).
  - CLEAR: clr_busy=1; entry[latched bank][index] ← 0 each cycle; index increments.
  - After index = DEPTH-1 is written → go to DONE. CLEAR lasts exactly DEPTH cycles.
  - DONE: clr_busy=0, clr_done=1 for one cycle, then IDLE.
  - clr_req while in CLEAR or DONE is ignored; it is not queued.
  - First new request is accepted in the cycle after DONE.
- Clear vs. host write:
  - During CLEAR, host writes to the latched bank are dropped.
  - Host writes to other banks proceed normally.
- Reads during CLEAR are allowed. Reads of the clearing bank return current contents, which may be partially cleared.
- Reset mid-clear: FSM returns to IDLE immediately, all entries = 0, no clr_done pulse.

Optional Feature:
- Macro: BANKED_REG_ARRAY_BYPASS_EN.
- Defined: write-to-read forwarding. When wr_en and rd_en hit the same in-range [bank][addr] in one cycle and the write is accepted, rd_data = wr_data after that edge. A write dropped by an active clear is not forwarded.
- Not defined: read returns the old stored value, as specified above. No other behaviour changes.

Test Plan:
- Reset then read all entries, WIDTH=8, DEPTH=8, BANKS=2 → every read: rd_data=0x00, rd_valid=1 one cycle after rd_en; clr_busy=0.
- Write bank1 addr5 = 0xA5, then read bank1 addr5 and bank0 addr5 → 0xA5, then 0x00, each with latency 1.
- Same-cycle write 0x3C and read of bank0 addr2 (previously 0x11) → rd_data=0x11 without macro; 0x3C with BANKED_REG_ARRAY_BYPASS_EN.
- Fill bank0 with 0xFF, pulse clr_req with clr_bank=0 → clr_busy high for exactly 8 cycles, then clr_done pulses once; all bank0 reads = 0x00; bank1 contents unchanged.
- During clear of bank0, write 0x77 to bank0 addr7 and bank1 addr7, and pulse clr_req again → bank0 addr7 reads 0x00, bank1 addr7 reads 0x77, only one clr_done pulse.
- DEPTH=6: write to addr 6 and 7, then read addr 7 → writes dropped, read returns 0x00 with rd_valid=1. Assert rstn low mid-clear → outputs 0 immediately, no clr_done pulse.
